// File: rtl/hazard_if.sv
// Bundle between the pipeline and the hazard controller: ID/EX status in,
// stage-register control and registered halt/statistics out.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rs_reg;
  logic [3:0]       id_rt_reg;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [3:0]       ex_rd;
  logic             ex_WriteReg;
  logic             ex_hlt;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_wen;
  logic             if_id_stall_n;
  logic             id_ex_stall_n;
  logic             if_id_flush;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs_reg, id_rt_reg, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           ex_WriteReg, ex_hlt, branch_taken, mem_busy,
    input  pc_wen, if_id_stall_n, id_ex_stall_n, if_id_flush, halted, mem_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs_reg, id_rt_reg, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           ex_WriteReg, ex_hlt, branch_taken, mem_busy,
    output pc_wen, if_id_stall_n, id_ex_stall_n, if_id_flush, halted, mem_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, branch flush, memory
// freeze with timeout, HLT handling and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_wen, if_id_stall_n, id_ex_stall_n, if_id_flush;
  logic lu_hit;

  assign lu_hit = hz.ex_memread & hz.ex_WriteReg & (hz.ex_rd != 4'd0) &
                  ((hz.id_uses_rs & (hz.id_rs_reg == hz.ex_rd)) |
                   (hz.id_uses_rt & (hz.id_rt_reg == hz.ex_rd)));

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    pc_wen        = 1'b0;
    if_id_stall_n = 1'b0;
    id_ex_stall_n = 1'b0;
    if_id_flush   = 1'b0;

    if (state_q == HALT) begin
      state_d = HALT;
    end else if (state_q == MEM_WAIT && hz.mem_busy) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
        state_d   = HALT;
        mem_err_d = 1'b1;
      end
    end else begin
      // A MEM_WAIT cycle whose memory just became ready behaves as RUN.
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      if (hz.mem_busy) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = 8'd1;
      end else if (hz.ex_hlt) begin
        id_ex_stall_n = 1'b1;
        state_d       = HALT;
      end else if (lu_hit) begin
        id_ex_stall_n = 1'b1;
      end else begin
        pc_wen        = 1'b1;
        if_id_stall_n = 1'b1;
        id_ex_stall_n = 1'b1;
        if_id_flush   = hz.branch_taken;
      end
    end

    halted_d = (state_d == HALT);

    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALT) begin
      if (!pc_wen && stall_q != '1) stall_d = stall_q + 1'b1;
      if (if_id_flush && flush_q != '1) flush_d = flush_q + 1'b1;
    end

    if (rst) begin
      pc_wen        = 1'b0;
      if_id_stall_n = 1'b0;
      id_ex_stall_n = 1'b0;
      if_id_flush   = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      halted_q   <= 1'b0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hz.pc_wen        = pc_wen;
  assign hz.if_id_stall_n = if_id_stall_n;
  assign hz.id_ex_stall_n = id_ex_stall_n;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.halted        = halted_q;
  assign hz.mem_err       = mem_err_q;
  assign hz.stall_cycles  = stall_q;
  assign hz.flush_count   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-width instance and a narrow
// instance (CNT_W=2, MEM_TIMEOUT=4) for saturation and timeout behaviour.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, rst_s;
  logic sel;  // 0: main instance under test, 1: narrow instance

  hazard_if #(.CNT_W(16)) hm ();
  hazard_if #(.CNT_W(2))  hs ();

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) u_main  (.clk(clk), .rst(rst_m), .hz(hm));
  hazard_ctrl #(.CNT_W(2),  .MEM_TIMEOUT(4))   u_small (.clk(clk), .rst(rst_s), .hz(hs));

  typedef struct packed {
    logic        pc_wen;
    logic        ifid;
    logic        idex;
    logic        flush;
    logic        halted;
    logic        mem_err;
    logic [15:0] stall;
    logic [15:0] flush_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference counters, reset and saturating as the block's statistics should.
  logic [15:0] m_stall, m_flush;
  logic        m_halt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    if (sel) begin
      o = '{hs.pc_wen, hs.if_id_stall_n, hs.id_ex_stall_n, hs.if_id_flush,
            hs.halted, hs.mem_err, 16'(hs.stall_cycles), 16'(hs.flush_count)};
    end else begin
      o = '{hm.pc_wen, hm.if_id_stall_n, hm.id_ex_stall_n, hm.if_id_flush,
            hm.halted, hm.mem_err, hm.stall_cycles, hm.flush_count};
    end
    return o;
  endfunction

  task automatic set_rst(input logic v);
    if (sel) rst_s = v;
    else     rst_m = v;
  endtask

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic [3:0] rd,
                       input logic wr, input logic hlt, input logic br, input logic busy);
    if (sel) begin
      hs.id_rs_reg = rs; hs.id_rt_reg = rt; hs.id_uses_rs = urs; hs.id_uses_rt = urt;
      hs.ex_memread = mr; hs.ex_rd = rd; hs.ex_WriteReg = wr; hs.ex_hlt = hlt;
      hs.branch_taken = br; hs.mem_busy = busy;
    end else begin
      hm.id_rs_reg = rs; hm.id_rt_reg = rt; hm.id_uses_rs = urs; hm.id_uses_rt = urt;
      hm.ex_memread = mr; hm.ex_rd = rd; hm.ex_WriteReg = wr; hm.ex_hlt = hlt;
      hm.branch_taken = br; hm.mem_busy = busy;
    end
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: expected control outputs for this cycle and registered outputs
  // after the edge are queued, then compared mid-cycle and just after the edge.
  task automatic step(input string tag, input logic pc, input logic ifid, input logic idex,
                      input logic fl, input logic hlt, input logic err);
    exp_t        e, o;
    logic [15:0] cmax;
    logic        in_rst;
    cmax   = sel ? 16'd3 : 16'hFFFF;
    in_rst = sel ? rst_s : rst_m;
    if (in_rst) begin
      m_stall = '0;
      m_flush = '0;
    end else if (!m_halt) begin
      if (!pc && m_stall != cmax) m_stall++;
      if (fl && m_flush != cmax)  m_flush++;
    end
    m_halt = hlt;
    sb_q.push_back('{pc, ifid, idex, fl, hlt, err, m_stall, m_flush});

    @(negedge clk);
    e = sb_q.pop_front();
    o = observe();
    check({tag, ".pc_wen"},        16'(o.pc_wen), 16'(e.pc_wen));
    check({tag, ".if_id_stall_n"}, 16'(o.ifid),   16'(e.ifid));
    check({tag, ".id_ex_stall_n"}, 16'(o.idex),   16'(e.idex));
    check({tag, ".if_id_flush"},   16'(o.flush),  16'(e.flush));
    @(posedge clk);
    #1;
    o = observe();
    check({tag, ".halted"},       16'(o.halted),  16'(e.halted));
    check({tag, ".mem_err"},      16'(o.mem_err), 16'(e.mem_err));
    check({tag, ".stall_cycles"}, o.stall,        e.stall);
    check({tag, ".flush_count"},  o.flush_cnt,    e.flush_cnt);
  endtask

  initial begin
    rst_m = 1'b1; rst_s = 1'b1;
    m_stall = '0; m_flush = '0; m_halt = 1'b0;
    sel = 1'b1; idle();
    sel = 1'b0; idle();
    @(posedge clk); #1;

    // ---------------- main instance ----------------
    step("reset", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0);

    drive(4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, 0, 0);  step("lu_rs", 0, 0, 1, 0, 0, 0);
    idle();                                         step("after_lu", 1, 1, 1, 0, 0, 0);
    drive(4'd0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 0, 0);  step("rd_zero", 1, 1, 1, 0, 0, 0);
    drive(4'd3, 4'd0, 0, 0, 1, 4'd3, 1, 0, 0, 0);  step("rs_unused", 1, 1, 1, 0, 0, 0);
    drive(4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 0, 0, 0);  step("no_wreg", 1, 1, 1, 0, 0, 0);
    drive(4'd0, 4'd5, 0, 1, 1, 4'd5, 1, 0, 0, 0);  step("lu_rt", 0, 0, 1, 0, 0, 0);

    drive(4'd1, 4'd2, 1, 1, 0, 4'd1, 1, 0, 1, 0);  step("branch", 1, 1, 1, 1, 0, 0);
    drive(4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, 1, 0);  step("branch_lu", 0, 0, 1, 0, 0, 0);

    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("mem_busy", 0, 0, 0, 0, 0, 0);
    idle();                                         step("mem_release", 1, 1, 1, 0, 0, 0);

    drive(4'd7, 4'd0, 1, 0, 1, 4'd7, 1, 0, 0, 1);  step("busy_over_lu", 0, 0, 0, 0, 0, 0);
    drive(4'd7, 4'd0, 1, 0, 1, 4'd7, 1, 0, 0, 0);  step("lu_on_release", 0, 0, 1, 0, 0, 0);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);  step("busy_again", 0, 0, 0, 0, 0, 0);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);  step("branch_on_release", 1, 1, 1, 1, 0, 0);

    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);  step("busy_pre_rst", 0, 0, 0, 0, 0, 0);
    set_rst(1'b1);                                  step("rst_in_wait", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0); idle();                          step("run_after_rst", 1, 1, 1, 0, 0, 0);

    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0);  step("hlt", 0, 0, 1, 0, 1, 0);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("halt_hold", 0, 0, 0, 0, 1, 0);
    set_rst(1'b1);                                  step("rst_in_halt", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0); idle();                          step("run_after_halt", 1, 1, 1, 0, 0, 0);

    // ---------------- narrow instance ----------------
    rst_m = 1'b1;
    sel = 1'b1;
    m_halt = 1'b0;
    step("s_reset", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0);

    drive(4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("s_lu_sat", 0, 0, 1, 0, 0, 0);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("s_flush_sat", 1, 1, 1, 1, 0, 0);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0);  step("s_hlt", 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("s_halt_hold", 0, 0, 0, 0, 1, 0);
    set_rst(1'b1);                                  step("s_rst_halt", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0);

    // RUN cycle plus MEM_WAIT cycles with wait_cnt 1..3 stay frozen; wait_cnt 4 times out.
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("s_wait", 0, 0, 0, 0, 0, 0);
    step("s_timeout", 0, 0, 0, 0, 1, 1);
    step("s_err_hold", 0, 0, 0, 0, 1, 1);
    set_rst(1'b1);                                  step("s_rst_err", 0, 0, 0, 0, 0, 0);
    set_rst(1'b0); idle();                          step("s_run_after", 1, 1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
